if_fetch_unit: RTL and testbench

//  Instruction-fetch stage; the write side of the IF/ID register. Owns the PC and issues one

---
 rtl/if_fetch_unit_if.sv | 21 ++
 rtl/if_fetch_unit.sv | 132 +++++++++++++
 tb/tb_if_fetch_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface if_fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight, feeds IF/ID.
// Optional IF_FETCH_PERF_EN adds fetch/stall/kill performance counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  keep_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    if_fetch_unit_if.master       imem,
    output logic                  valid_o,
    output logic [31:0]           pc_o,
    output logic [31:0]           pc4_o,
    output logic [31:0]           inst_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetch_o,
    output logic [31:0]           perf_stall_o,
    output logic [31:0]           perf_kill_o
`endif
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_c;
    logic [31:0] redirect_tgt_c;
    logic        req_c;
    logic [31:0] addr_c;
    logic        kill_c;

    assign pc4_c          = pc_q + 32'd4;
    assign redirect_tgt_c = redirect_pc_i & ~32'h0000_0003;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // Redirect overrides keep and rvalid; a live fetch becomes a drop.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        req_c   = 1'b0;
        addr_c  = pc_q;
        kill_c  = 1'b0;
        case (state_q)
            S_REQ: begin
                if (redirect_i) begin
                    pc_d = redirect_tgt_c;
                end else begin
                    req_c   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    pc_d    = redirect_tgt_c;
                    kill_c  = imem.imem_rvalid_i;
                    state_d = imem.imem_rvalid_i ? S_REQ : S_DROP;
                end else if (imem.imem_rvalid_i) begin
                    inst_d  = imem.imem_rdata_i;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (redirect_i) begin
                    pc_d    = redirect_tgt_c;
                    state_d = S_REQ;
                end else if (!keep_i) begin
                    pc_d    = pc4_c;
                    req_c   = 1'b1;
                    addr_c  = pc4_c;
                    state_d = S_WAIT;
                end
            end
            S_DROP: begin
                if (redirect_i) begin
                    pc_d = redirect_tgt_c;
                end
                if (imem.imem_rvalid_i) begin
                    kill_c  = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign imem.imem_req_o  = req_c;
    assign imem.imem_addr_o = addr_c;
    assign valid_o          = (state_q == S_VALID);
    assign pc_o             = pc_q;
    assign pc4_o            = pc4_c;
    assign inst_o           = (state_q == S_VALID) ? inst_q : NOP_INST;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q, kill_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
            kill_cnt_q  <= 32'd0;
        end else begin
            if (state_q == S_VALID && !keep_i && !redirect_i) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (state_q == S_VALID && keep_i)                 stall_cnt_q <= stall_cnt_q + 32'd1;
            if (kill_c)                                       kill_cnt_q  <= kill_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_o = fetch_cnt_q;
    assign perf_stall_o = stall_cnt_q;
    assign perf_kill_o  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, mid-fetch reset, then randomized run vs a flag-level model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        keep;
    logic        redir;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] pc, pc4, inst;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_stall, perf_kill;
`endif

    int tests = 0;
    int fails = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .keep_i        (keep),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .imem          (bus),
        .valid_o       (valid),
        .pc_o          (pc),
        .pc4_o         (pc4),
        .inst_o        (inst)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_o  (perf_fetch),
        .perf_stall_o  (perf_stall),
        .perf_kill_o   (perf_kill)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        keep;
        logic        redir;
        logic [31:0] rpc;
        logic        rv;
        logic [31:0] rdata;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Abstract model: pc plus flags for "request outstanding", "outstanding one is killed", "instruction held".
    logic [31:0] m_pc;
    logic        m_busy, m_kill, m_hold;
    logic [31:0] m_fetch, m_stall, m_kills;
    // Memory: a single pending response with a countdown.
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;

    initial begin
        vecs[0]  = '{1'b0,1'b0,32'h0,1'b0,32'h0,          1'b0,32'h0,NOP,1'b1,32'h0};
        vecs[1]  = '{1'b0,1'b0,32'h0,1'b1,32'h0050_0093,  1'b0,32'h0,NOP,1'b0,32'h0};
        vecs[2]  = '{1'b1,1'b0,32'h0,1'b0,32'h0,          1'b1,32'h0,32'h0050_0093,1'b0,32'h0};
        vecs[3]  = '{1'b1,1'b0,32'h0,1'b0,32'h0,          1'b1,32'h0,32'h0050_0093,1'b0,32'h0};
        vecs[4]  = '{1'b1,1'b0,32'h0,1'b0,32'h0,          1'b1,32'h0,32'h0050_0093,1'b0,32'h0};
        vecs[5]  = '{1'b1,1'b0,32'h0,1'b0,32'h0,          1'b1,32'h0,32'h0050_0093,1'b0,32'h0};
        vecs[6]  = '{1'b0,1'b0,32'h0,1'b0,32'h0,          1'b1,32'h0,32'h0050_0093,1'b1,32'h4};
        vecs[7]  = '{1'b0,1'b1,32'h80,1'b0,32'h0,         1'b0,32'h4,NOP,1'b0,32'h0};
        vecs[8]  = '{1'b0,1'b0,32'h0,1'b0,32'h0,          1'b0,32'h80,NOP,1'b0,32'h0};
        vecs[9]  = '{1'b0,1'b0,32'h0,1'b1,32'hDEAD_BEEF,  1'b0,32'h80,NOP,1'b0,32'h0};
        vecs[10] = '{1'b0,1'b0,32'h0,1'b0,32'h0,          1'b0,32'h80,NOP,1'b1,32'h80};
        vecs[11] = '{1'b0,1'b0,32'h0,1'b1,32'h1111_1111,  1'b0,32'h80,NOP,1'b0,32'h0};
        vecs[12] = '{1'b0,1'b0,32'h0,1'b0,32'h0,          1'b1,32'h80,32'h1111_1111,1'b1,32'h84};
        vecs[13] = '{1'b0,1'b1,32'h103,1'b1,32'h2222_2222,1'b0,32'h84,NOP,1'b0,32'h0};
        vecs[14] = '{1'b0,1'b0,32'h0,1'b0,32'h0,          1'b0,32'h100,NOP,1'b1,32'h100};
        vecs[15] = '{1'b0,1'b0,32'h0,1'b1,32'h3333_3333,  1'b0,32'h100,NOP,1'b0,32'h0};
        vecs[16] = '{1'b1,1'b1,32'h200,1'b0,32'h0,        1'b1,32'h100,32'h3333_3333,1'b0,32'h0};
        vecs[17] = '{1'b0,1'b0,32'h0,1'b0,32'h0,          1'b0,32'h200,NOP,1'b1,32'h200};
        vecs[18] = '{1'b0,1'b0,32'h0,1'b1,32'h4444_4444,  1'b0,32'h200,NOP,1'b0,32'h0};
        vecs[19] = '{1'b0,1'b1,32'hFFFF_FFFE,1'b0,32'h0,  1'b1,32'h200,32'h4444_4444,1'b0,32'h0};
        vecs[20] = '{1'b0,1'b0,32'h0,1'b0,32'h0,          1'b0,32'hFFFF_FFFC,NOP,1'b1,32'hFFFF_FFFC};
        vecs[21] = '{1'b0,1'b0,32'h0,1'b1,32'h5555_5555,  1'b0,32'hFFFF_FFFC,NOP,1'b0,32'h0};
        vecs[22] = '{1'b0,1'b0,32'h0,1'b0,32'h0,          1'b1,32'hFFFF_FFFC,32'h5555_5555,1'b1,32'h0};
        vecs[23] = '{1'b0,1'b0,32'h0,1'b0,32'h0,          1'b0,32'h0,NOP,1'b0,32'h0};

        rst   = 1'b1;
        keep  = 1'b0;
        redir = 1'b0;
        rpc   = 32'h0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 0, 32'(valid), 32'd0);
        chk("rst_pc",    0, pc,  32'h0);
        chk("rst_pc4",   0, pc4, 32'h4);
        chk("rst_inst",  0, inst, NOP);
        rst = 1'b0;

        // Directed table, one row per cycle starting with the first cycle after reset release.
        for (int i = 0; i < 24; i++) begin
            keep  = vecs[i].keep;
            redir = vecs[i].redir;
            rpc   = vecs[i].rpc;
            bus.imem_rvalid_i = vecs[i].rv;
            bus.imem_rdata_i  = vecs[i].rdata;
            @(negedge clk);
            chk("tbl_valid", i, 32'(valid), 32'(vecs[i].e_valid));
            chk("tbl_pc",    i, pc,   vecs[i].e_pc);
            chk("tbl_pc4",   i, pc4,  vecs[i].e_pc + 32'd4);
            chk("tbl_inst",  i, inst, vecs[i].e_inst);
            chk("tbl_req",   i, 32'(bus.imem_req_o), 32'(vecs[i].e_req));
            if (vecs[i].e_req) chk("tbl_addr", i, bus.imem_addr_o, vecs[i].e_addr);
            @(posedge clk);
            #1;
        end

        // Reset asserted while waiting on memory takes effect without a clock edge.
        keep  = 1'b0;
        redir = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 0, 32'(valid), 32'd0);
        chk("mid_rst_inst",  0, inst, NOP);
        chk("mid_rst_pc",    0, pc,   32'h0);
`ifdef IF_FETCH_PERF_EN
        chk("mid_rst_pfetch", 0, perf_fetch, 32'd0);
        chk("mid_rst_pstall", 0, perf_stall, 32'd0);
        chk("mid_rst_pkill",  0, perf_kill,  32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        m_pc = 32'h0; m_busy = 1'b0; m_kill = 1'b0; m_hold = 1'b0;
        m_fetch = 32'd0; m_stall = 32'd0; m_kills = 32'd0;
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'h0;

        for (int c = 0; c < 4000; c++) begin
            logic        rv;
            logic        e_req;
            logic [31:0] e_addr;
            rv = 1'b0;
            if (mem_pend) begin
                if (mem_cnt == 0) begin
                    rv = 1'b1;
                    mem_pend = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            bus.imem_rvalid_i = rv;
            bus.imem_rdata_i  = rv ? memf(mem_addr) : $urandom;
            keep  = ($urandom % 10) < 4;
            redir = ($urandom % 12) == 0;
            rpc   = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;

            @(negedge clk);
            if (redir)       e_req = 1'b0;
            else if (m_hold) e_req = !keep;
            else             e_req = !m_busy;
            e_addr = m_hold ? m_pc + 32'd4 : m_pc;

            chk("rnd_valid", c, 32'(valid), 32'(m_hold));
            chk("rnd_pc",    c, pc,   m_pc);
            chk("rnd_pc4",   c, pc4,  m_pc + 32'd4);
            chk("rnd_inst",  c, inst, m_hold ? memf(m_pc) : NOP);
            chk("rnd_req",   c, 32'(bus.imem_req_o), 32'(e_req));
            if (e_req) chk("rnd_addr", c, bus.imem_addr_o, e_addr);
`ifdef IF_FETCH_PERF_EN
            chk("rnd_pfetch", c, perf_fetch, m_fetch);
            chk("rnd_pstall", c, perf_stall, m_stall);
            chk("rnd_pkill",  c, perf_kill,  m_kills);
`endif
            if (bus.imem_req_o) begin
                mem_pend = 1'b1;
                mem_cnt  = int'($urandom % 4);
                mem_addr = bus.imem_addr_o;
            end

            if (m_hold && !keep && !redir) m_fetch = m_fetch + 32'd1;
            if (m_hold && keep)            m_stall = m_stall + 32'd1;
            if (m_busy && rv && (m_kill || redir)) m_kills = m_kills + 32'd1;

            if (redir) begin
                m_pc   = {rpc[31:2], 2'b00};
                m_hold = 1'b0;
                m_kill = m_busy && !rv;
                m_busy = m_busy && !rv;
            end else if (m_hold) begin
                if (!keep) begin
                    m_pc   = m_pc + 32'd4;
                    m_hold = 1'b0;
                    m_busy = 1'b1;
                end
            end else if (!m_busy) begin
                m_busy = 1'b1;
            end else if (rv) begin
                m_busy = 1'b0;
                m_hold = !m_kill;
                m_kill = 1'b0;
            end

            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
